// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: phase-pair encodings,
// direction codes and the forward (up) Gray-code successor function.
package quad_pkg;

  // Synchronized phase pair ab = {A,B}
  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } ab_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Up sequence 00 -> 10 -> 11 -> 01 -> 00 (A leads B)
  function automatic ab_t next_up(input ab_t s);
    case (s)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      default: return S00;
    endcase
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// One encoder phase: 2-FF synchronizer, optionally followed by a stability
// filter (enabled with QUAD_GLITCH_FILTER_EN). o_vld rises once o_q carries
// a real pin sample rather than the reset value of the pipeline.
module quad_sync_filter
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_vld
);

  logic       r_meta;
  logic       r_sync;
  logic [1:0] r_fill;

  // Synchronizer chain and pipeline-fill tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_fill <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_fill <= {r_fill[0], 1'b1};
    end
  end

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic          r_primed;

  // Accept a new level only after FILTER_LEN consecutive differing samples;
  // the first valid sample is loaded directly so idle levels held through
  // reset are not seen as a transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_primed <= 1'b0;
    end else if (!r_primed) begin
      r_cnt <= '0;
      if (r_fill[1]) begin
        r_out    <= r_sync;
        r_primed <= 1'b1;
      end
    end else if (r_sync == r_out) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_out <= r_sync;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_q   = r_out;
  assign o_vld = r_primed;
`else
  assign o_q   = r_sync;
  assign o_vld = r_fill[1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder top: synchronizes both phases, classifies each change
// of ab = {A,B} as up/down/illegal, and keeps a wrapping position count.
// Optional glitch filter: define QUAD_GLITCH_FILTER_EN.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clr,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] pos,
  output logic             err
);

  logic             w_a, w_b, w_va, w_vb;
  ab_t              w_ab;
  logic             w_up, w_dn, w_ill;
  ab_t              r_prev;
  logic             r_primed;
  logic             r_step, r_dir, r_err;
  logic [WIDTH-1:0] r_pos;

  quad_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_a (
    .clk(clk), .rst(rst), .i_d(quad_a), .o_q(w_a), .o_vld(w_va)
  );

  quad_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_b (
    .clk(clk), .rst(rst), .i_d(quad_b), .o_q(w_b), .o_vld(w_vb)
  );

  // Transition classification against the previous sample
  always_comb begin
    w_ab  = ab_t'({w_a, w_b});
    w_up  = r_primed && (w_ab == next_up(r_prev));
    w_dn  = r_primed && (r_prev == next_up(w_ab));
    w_ill = r_primed && (w_ab != r_prev) && !w_up && !w_dn;
  end

  // Decoder state; priming waits until the synchronizers hold real pin
  // samples, so levels present during reset never register as a transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev   <= S00;
      r_primed <= 1'b0;
      r_step   <= 1'b0;
      r_dir    <= DIR_UP;
      r_pos    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_prev <= w_ab;
      r_step <= 1'b0;
      if (!r_primed) r_primed <= w_va && w_vb;
      if (clr) begin
        r_pos <= '0;
        r_err <= w_ill;
      end else begin
        if (w_ill) r_err <= 1'b1;
        if (w_up || w_dn) begin
          r_step <= 1'b1;
          r_dir  <= w_up ? DIR_UP : DIR_DN;
          r_pos  <= w_up ? r_pos + 1'b1 : r_pos - 1'b1;
        end
      end
    end
  end

  assign step = r_step;
  assign dir  = r_dir;
  assign pos  = r_pos;
  assign err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=8, FILTER_LEN=4).
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst, quad_a, quad_b, clr;
  logic       step, dir, err;
  logic [7:0] pos;
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int STEP_TICK = 7;
`else
  localparam int STEP_TICK = 3;
`endif

  quad_decoder #(.WIDTH(8), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b), .clr(clr),
    .step(step), .dir(dir), .pos(pos), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply a new phase pair and watch 10 cycles: step expected only at STEP_TICK
  task automatic move(input logic a, input logic b, input logic exp_step, input string tag);
    int unsigned seen;
    seen   = 0;
    quad_a = a;
    quad_b = b;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == STEP_TICK) chk({tag, "_step"}, step, exp_step);
      else seen += step;
    end
    chk({tag, "_extra"}, seen, 0);
  endtask

  initial begin
    int unsigned cnt_s, cnt_e;
    rst = 1'b1; quad_a = 1'b0; quad_b = 1'b0; clr = 1'b0;
    repeat (3) tick();
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 1);
    chk("rst_pos", pos, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("prime_step", step, 0);
    chk("prime_err", err, 0);

    // four up transitions from 00
    move(1, 0, 1, "up1");
    move(1, 1, 1, "up2");
    move(0, 1, 1, "up3");
    move(0, 0, 1, "up4");
    chk("up_pos", pos, 4);
    chk("up_dir", dir, 1);
    chk("up_err", err, 0);

    // eight down transitions wrap past zero
    for (int n = 0; n < 2; n++) begin
      move(0, 1, 1, "dn_a");
      move(1, 1, 1, "dn_b");
      move(1, 0, 1, "dn_c");
      move(0, 0, 1, "dn_d");
    end
    chk("dn_pos", pos, 252);
    chk("dn_dir", dir, 0);

    // illegal 00 -> 11
    move(1, 1, 0, "ill");
    chk("ill_err", err, 1);
    chk("ill_pos", pos, 252);
    chk("ill_dir", dir, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_pos", pos, 0);
    chk("clr_err", err, 0);

    // zero minus one wraps to all-ones, then count down to 252 from 11
    move(1, 0, 1, "w1");
    chk("wrap_pos", pos, 255);
    move(0, 0, 1, "w2");
    move(0, 1, 1, "w3");
    move(1, 1, 1, "w4");
    chk("pre_rst_pos", pos, 252);

    // reset mid-count with inputs held at 11
    rst = 1'b1; tick();
    chk("mrst_step", step, 0);
    chk("mrst_dir", dir, 1);
    chk("mrst_pos", pos, 0);
    chk("mrst_err", err, 0);
    rst = 1'b0;
    cnt_s = 0; cnt_e = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt_s += step;
      cnt_e += err;
    end
    chk("mprime_steps", cnt_s, 0);
    chk("mprime_errs", cnt_e, 0);
    move(0, 1, 1, "post_rst");
    chk("post_rst_pos", pos, 1);
    chk("post_rst_dir", dir, 1);

    // clr coinciding with a legal step (01 -> 00 up)
    quad_a = 1'b0; quad_b = 1'b0;
    repeat (STEP_TICK - 1) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clrstep_step", step, 0);
    chk("clrstep_pos", pos, 0);
    chk("clrstep_dir", dir, 1);
    repeat (5) tick();
    chk("clrstep_pos2", pos, 0);

    // clr coinciding with an illegal jump (00 -> 11)
    quad_a = 1'b1; quad_b = 1'b1;
    repeat (STEP_TICK - 1) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clrill_err", err, 1);
    chk("clrill_step", step, 0);
    chk("clrill_pos", pos, 0);
    repeat (5) tick();

`ifdef QUAD_GLITCH_FILTER_EN
    clr = 1'b1; tick(); clr = 1'b0;
    chk("f_clr_err", err, 0);
    // 2-cycle glitch on A is discarded
    quad_a = 1'b0; tick(); tick(); quad_a = 1'b1;
    cnt_s = 0; cnt_e = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt_s += step;
      cnt_e += err;
    end
    chk("f_glitch_steps", cnt_s, 0);
    chk("f_glitch_errs", cnt_e, 0);
    chk("f_glitch_pos", pos, 0);
    // held change: one step, 6 cycles after the change
    move(0, 1, 1, "f_hold");
    chk("f_hold_pos", pos, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder for an incremental encoder. It samples the two asynchronous phase inputs, resolves each legal Gray-code transition into a one-cycle step pulse plus a direction, and keeps a wrapping position count. It is the producer side for the up/down counter: it generates the count/direction information that the counter consumes, with position tracking built in. It sits at the board-input boundary, between encoder pins and control logic.

## Interface
Parameters:
- WIDTH, 8: position counter width in bits.
- FILTER_LEN, 4: number of cycles a synchronized input must stay stable before it is accepted. Used only when QUAD_GLITCH_FILTER_EN is defined; must be ≥1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- quad_a  input  1  encoder phase A, asynchronous to clk.
- quad_b  input  1  encoder phase B, asynchronous to clk.
- clr  input  1  synchronous clear of pos and err.
- step  output  1  one-cycle pulse per accepted legal transition.
- dir  output  1  direction of the last accepted step: 1 = up, 0 = down.
- pos  output  WIDTH  position count.
- err  output  1  sticky flag for an illegal transition.

## Operation
- Each phase passes through a 2-FF synchronizer. The synchronized pair is ab = {A,B}.
- Up sequence: 00→10→11→01→00, with A leading. Down is the exact reverse.
- Each cycle, ab is compared with the registered previous value prev:
  - Same value: no action.
  - Legal up step: step=1, dir=1, pos+1.
  - Legal down step: step=1, dir=0, pos−1.
  - Both bits changed (00↔11, 10↔01): err←1. No step, pos and dir unchanged.
- prev is always updated to ab.
- pos arithmetic is modulo 2^WIDTH. All-ones + up gives 0. Zero + down gives all-ones.
- Priming: after reset, a primed flag is 0. The first cycle loads prev from ab with no step and no err, then sets primed. Inputs idling at 11 or any other value during reset therefore cause no spurious count.
- clr:
  - pos←0.
  - err←0, unless an illegal transition is detected in the same cycle. Setting err wins, so errors are never lost.
  - step is suppressed that cycle.
  - prev still updates.
  - dir is unchanged.
- Reset values: step=0, dir=1, pos=0, err=0, prev=00, primed=0, synchronizers=0, filter counters=0.

## Timing
- A phase change sampled first at edge k reaches ab at edge k+1. The step, pos and dir update are registered at edge k+2, giving 2 cycles of latency from first sample, filter disabled.
- step is high for exactly one cycle per transition. Transitions are resolvable only if ab changes at most once per cycle; faster inputs produce err.
- rst asserted mid-operation forces all reset values at the next edge, regardless of clr or inputs. Priming restarts afterwards.
- clr is effective at the edge it is sampled. pos reads 0 in the following cycle.

## Configuration
- QUAD_GLITCH_FILTER_EN defined:
  - Each synchronized phase feeds a stability filter. A new level is accepted only after FILTER_LEN consecutive identical samples.
  - Shorter pulses are discarded.
  - Adds FILTER_LEN cycles of latency, for a total of 2+FILTER_LEN.
- Undefined: the filter is absent, synchronizer outputs feed the decoder directly, and FILTER_LEN is ignored.

## Structure
- Package quad_pkg holds:
  - Localparams for the four ab states (S00, S10, S11, S01).
  - DIR_UP = 1 and DIR_DN = 0.
  - A function returning the next-up state for a given state.
- Sub-module quad_sync_filter (one per phase, instantiated twice): 2-FF synchronizer plus the stability filter guarded by QUAD_GLITCH_FILTER_EN.
- Top level holds prev, primed, the decode logic, pos, dir, step and err.

## Test plan
- Reset with A=B=0, then 4 up transitions spaced 10 cycles → 4 single-cycle step pulses, dir=1, pos=4, err=0, each step 2 cycles after the input change.
- From pos=4, 8 down transitions → pos=252 (WIDTH=8 wrap), dir=0.
- Illegal 00→11 jump → err=1, no step, pos unchanged. Then clr → err=0, pos=0.
- Assert rst mid-count with inputs held at 11 → all outputs take reset values. The first post-reset cycle gives no step and no err, and the next legal 11→01 gives pos=1.
- clr in the same cycle as a legal step → pos=0 and step=0. clr in the same cycle as an illegal jump → err=1.
- Filter enabled with FILTER_LEN=4: a 2-cycle glitch on A → no step. A held 10 cycles → exactly one step, 6 cycles after the change.
